// File: rtl/arbitro_rr_c_if.sv
// Handshake bundle between the round-robin arbiter, its NF source FIFOs and the
// shared destination FIFO. The master side is the arbiter.
interface arbitro_rr_c_if #(
    parameter int NF = 4,
    parameter int DW = 8
) ();
    logic [NF-1:0]    fifo_empty;
    logic [NF-1:0]    valid_in;
    logic [NF*DW-1:0] data_in;
    logic             dest_almost_full;
    logic [NF:0]      error_in;
    logic [NF-1:0]    pop;
    logic             push_out;
    logic [DW-1:0]    data_out;

    modport master (
        input  fifo_empty, valid_in, data_in, dest_almost_full, error_in,
        output pop, push_out, data_out
    );

    modport slave (
        output fifo_empty, valid_in, data_in, dest_almost_full, error_in,
        input  pop, push_out, data_out
    );
endinterface

// File: rtl/arbitro_rr_c.sv
// Round-robin pop scheduler: pops at most one of NF source FIFOs per cycle and
// forwards the returned word as a push into one shared destination FIFO.
module arbitro_rr_c #(
    parameter int         NF      = 4,
    parameter int         DW      = 8,
    parameter logic [3:0] UAF_DEF = 4'd6,
    parameter logic [3:0] UAE_DEF = 4'd2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           init,
    input  logic [3:0]     umbral_af_in,
    input  logic [3:0]     umbral_ae_in,
    arbitro_rr_c_if.master bus,
    output logic [3:0]     umbral_almost_full,
    output logic [3:0]     umbral_almost_empty,
    output logic [4:0]     estado,
    output logic           idle,
    output logic           error_out
);
    localparam int PW = $clog2(NF);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW:0]   cand, cand_p1;
    logic [NF-1:0] pop_c;
    logic          grant;
    logic          multi_valid;
    logic [DW-1:0] fwd_data;
    logic          push_q;
    logic [DW-1:0] data_q;

    // Grant search. Pops are withheld while reset is low so that nothing
    // popped during reset can reach the destination afterwards.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant   = 1'b0;
        pop_c   = '0;
        ptr_nxt = ptr;
        cand    = '0;
        cand_p1 = '0;
        if (state == S_ACTIVE && !bus.dest_almost_full && reset) begin
            for (int k = 0; k < NF; k++) begin
                cand = {1'b0, ptr} + (PW+1)'(k);
                if (cand >= (PW+1)'(NF)) cand = cand - (PW+1)'(NF);
                if (!grant && !bus.fifo_empty[cand[PW-1:0]]) begin
                    grant   = 1'b1;
                    pop_c   = NF'(1) << cand[PW-1:0];
                    cand_p1 = cand + (PW+1)'(1);
                    ptr_nxt = (cand_p1 == (PW+1)'(NF)) ? '0 : cand_p1[PW-1:0];
                end
            end
        end
    end

    // Lowest-index valid source wins the forwarding slot.
    always_comb begin
        fwd_data = '0;
        for (int i = NF - 1; i >= 0; i--) begin
            if (bus.valid_in[i]) fwd_data = bus.data_in[i*DW +: DW];
        end
    end

    assign multi_valid = (bus.valid_in & (bus.valid_in - NF'(1))) != '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:  state_nxt = S_INIT;
            S_INIT:   if (!init) state_nxt = S_IDLE;
            S_IDLE:   if (!(&bus.fifo_empty) && !bus.dest_almost_full) state_nxt = S_ACTIVE;
            S_ACTIVE: if (&bus.fifo_empty) state_nxt = S_IDLE;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_RESET;
        endcase
        // A reported error or a double-valid protocol violation overrides everything.
        if (state != S_RESET && ((|bus.error_in) || multi_valid)) state_nxt = S_ERROR;
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state               <= S_RESET;
            ptr                 <= '0;
            push_q              <= 1'b0;
            data_q              <= '0;
            umbral_almost_full  <= UAF_DEF;
            umbral_almost_empty <= UAE_DEF;
        end else begin
            state <= state_nxt;
            if (grant) ptr <= ptr_nxt;
            if (state == S_INIT && init) begin
                umbral_almost_full  <= umbral_af_in;
                umbral_almost_empty <= umbral_ae_in;
            end
            // Gate on the next state so push_out is low for every ERROR cycle.
            if (state_nxt == S_ERROR) begin
                push_q <= 1'b0;
            end else begin
                push_q <= |bus.valid_in;
                if (|bus.valid_in) data_q <= fwd_data;
            end
        end
    end

    assign bus.pop      = pop_c;
    assign bus.push_out = push_q;
    assign bus.data_out = data_q;
    assign estado       = state;
    assign idle         = (state == S_IDLE);
    assign error_out    = (state == S_ERROR);
endmodule
